// File: rtl/module_bin2bcd_seq.sv
// +--------------------------------------------------------------------------+
// | module_bin2bcd_seq                                                       |
// | Sequential binary-to-BCD converter (shift-add-3) with start/busy/done    |
// | handshake, synchronised start request and saturating overflow output.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module module_bin2bcd_seq #(
  parameter int IN_WIDTH    = 16,
  parameter int N_DIGITS    = 4,
  parameter int SYNC_STAGES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_input,
  input  logic [IN_WIDTH-1:0]     numero_input,
  output logic                    busy_output,
  output logic                    done_output,
  output logic                    overflow_output,
  output logic [4*N_DIGITS-1:0]   bcd_output
);

  localparam int C_DW = 4 * N_DIGITS;
  localparam int C_CW = $clog2(IN_WIDTH + 1);
  localparam logic [C_CW-1:0] C_LAST_SHIFT = C_CW'(IN_WIDTH - 1);
  localparam logic [C_DW-1:0] C_ALL_NINES  = {N_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     edge_q;
  logic [IN_WIDTH-1:0]      bin_q;
  logic [C_DW-1:0]          digit_q;
  logic                     ovf_q;
  logic [C_CW-1:0]          cnt_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     ovf_out_q;
  logic [C_DW-1:0]          bcd_q;

  logic                     request_d;
  logic [C_DW-1:0]          corr_d;
  logic [C_DW+IN_WIDTH:0]   shift_d;
  logic                     carry_d;
  logic [C_DW-1:0]          digit_shift_d;
  logic [IN_WIDTH-1:0]      bin_shift_d;
  logic                     ovf_d;

  // Rising edge of the last synchroniser stage; a held level gives one request.
  assign request_d = sync_q[SYNC_STAGES-1] & ~edge_q;

  // All digits are corrected in parallel from their pre-shift values.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit_corr
    assign corr_d[4*k +: 4] = (digit_q[4*k +: 4] >= 4'd5) ? (digit_q[4*k +: 4] + 4'd3)
                                                            : digit_q[4*k +: 4];
  end

  assign shift_d       = {corr_d, bin_q, 1'b0};
  assign carry_d       = shift_d[C_DW+IN_WIDTH];
  assign digit_shift_d = shift_d[C_DW+IN_WIDTH-1:IN_WIDTH];
  assign bin_shift_d   = shift_d[IN_WIDTH-1:0];
  // Any bit carried out of the top digit means the operand needs more digits.
  assign ovf_d         = ovf_q | carry_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sync_q    <= '0;
      edge_q    <= 1'b0;
      bin_q     <= '0;
      digit_q   <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_out_q <= 1'b0;
      bcd_q     <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], start_input};
      edge_q <= sync_q[SYNC_STAGES-1];
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (request_d) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end

        ST_LOAD: begin
          bin_q   <= numero_input;
          digit_q <= '0;
          ovf_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_SHIFT;
        end

        ST_SHIFT: begin
          bin_q   <= bin_shift_d;
          digit_q <= digit_shift_d;
          ovf_q   <= ovf_d;
          cnt_q   <= cnt_q + 1'b1;
          // Results are registered on the last shift so they are valid with the done pulse.
          if (cnt_q == C_LAST_SHIFT) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            ovf_out_q <= ovf_d;
            bcd_q     <= ovf_d ? C_ALL_NINES : digit_shift_d;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_output     = busy_q;
  assign done_output     = done_q;
  assign overflow_output = ovf_out_q;
  assign bcd_output      = bcd_q;

endmodule

`default_nettype wire

// File: tb/tb_module_bin2bcd_seq.sv
// +--------------------------------------------------------------------------+
// | tb_module_bin2bcd_seq                                                    |
// | Directed bench for the sequential binary-to-BCD converter.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_module_bin2bcd_seq;

  localparam int SYNC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start_input = 1'b0;
  logic [15:0] numero_input = '0;
  logic        busy_output, done_output, overflow_output;
  logic [15:0] bcd_output;

  logic        start8 = 1'b0;
  logic [7:0]  num8 = '0;
  logic        busy8, done8, ovf8;
  logic [11:0] bcd8;

  logic        start20 = 1'b0;
  logic [19:0] num20 = '0;
  logic        busy20, done20, ovf20;
  logic [23:0] bcd20;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  module_bin2bcd_seq #(.IN_WIDTH(16), .N_DIGITS(4), .SYNC_STAGES(SYNC)) u_dut (
    .clk(clk), .rst(rst), .start_input(start_input), .numero_input(numero_input),
    .busy_output(busy_output), .done_output(done_output),
    .overflow_output(overflow_output), .bcd_output(bcd_output));

  module_bin2bcd_seq #(.IN_WIDTH(8), .N_DIGITS(3), .SYNC_STAGES(SYNC)) u_dut8 (
    .clk(clk), .rst(rst), .start_input(start8), .numero_input(num8),
    .busy_output(busy8), .done_output(done8),
    .overflow_output(ovf8), .bcd_output(bcd8));

  module_bin2bcd_seq #(.IN_WIDTH(20), .N_DIGITS(6), .SYNC_STAGES(SYNC)) u_dut20 (
    .clk(clk), .rst(rst), .start_input(start20), .numero_input(num20),
    .busy_output(busy20), .done_output(done20),
    .overflow_output(ovf20), .bcd_output(bcd20));

  typedef struct {
    logic [15:0] num;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle start pulse, then observe a fixed window counting busy/done.
  task automatic run_conv(input logic [15:0] n, input int win, output logic [15:0] bcd,
                          output logic ovf, output int lat, output int ndone, output int nbusy);
    @(negedge clk);
    numero_input = n;
    start_input  = 1'b1;
    lat = -1; ndone = 0; nbusy = 0; bcd = '0; ovf = 1'b0;
    for (int i = 1; i <= win; i++) begin
      @(posedge clk); #1;
      if (i == 1) start_input = 1'b0;
      if (busy_output) nbusy++;
      if (done_output) begin
        ndone++;
        if (lat < 0) begin
          lat = i; bcd = bcd_output; ovf = overflow_output;
        end
      end
    end
  endtask

  initial begin
    logic [15:0] r_bcd;
    logic        r_ovf;
    int          lat, ndone, nbusy;

    vecs[0] = '{16'd1234,  16'h1234, 1'b0};
    vecs[1] = '{16'd0,     16'h0000, 1'b0};
    vecs[2] = '{16'd9999,  16'h9999, 1'b0};
    vecs[3] = '{16'd10000, 16'h9999, 1'b1};
    vecs[4] = '{16'd65535, 16'h9999, 1'b1};
    vecs[5] = '{16'd42,    16'h0042, 1'b0};
    vecs[6] = '{16'd5,     16'h0005, 1'b0};
    vecs[7] = '{16'd8090,  16'h8090, 1'b0};
    vecs[8] = '{16'd1000,  16'h1000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy_output), 32'd0);
    check("reset_done", 32'(done_output), 32'd0);
    check("reset_ovf",  32'(overflow_output), 32'd0);
    check("reset_bcd",  32'(bcd_output), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      run_conv(vecs[v].num, 30, r_bcd, r_ovf, lat, ndone, nbusy);
      check($sformatf("v%0d_bcd", v),   32'(r_bcd), 32'(vecs[v].bcd));
      check($sformatf("v%0d_ovf", v),   32'(r_ovf), 32'(vecs[v].ovf));
      check($sformatf("v%0d_ndone", v), 32'(ndone), 32'd1);
      check($sformatf("v%0d_lat", v),   32'(lat),   32'(SYNC + 16 + 2));
      check($sformatf("v%0d_busy", v),  32'(nbusy), 32'd18);
      check($sformatf("v%0d_hold", v),  32'(bcd_output), 32'(vecs[v].bcd));
    end

    // Start held high for 100 cycles: one conversion only; operand changes after capture.
    @(negedge clk);
    numero_input = 16'd4321;
    start_input  = 1'b1;
    ndone = 0; r_bcd = '0;
    for (int i = 1; i <= 110; i++) begin
      @(posedge clk); #1;
      if (i == 10) numero_input = 16'd9;
      if (i == 100) start_input = 1'b0;
      if (done_output) begin ndone++; r_bcd = bcd_output; end
    end
    check("held_ndone", 32'(ndone), 32'd1);
    check("held_bcd",   32'(r_bcd), 32'h4321);

    // Second pulse while busy is ignored and not queued.
    @(negedge clk);
    numero_input = 16'd777;
    start_input  = 1'b1;
    ndone = 0; r_bcd = '0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 1 || i == 9) start_input = 1'b0;
      if (i == 8) start_input = 1'b1;
      if (i == 12) numero_input = 16'd1;
      if (done_output) begin ndone++; r_bcd = bcd_output; end
    end
    check("busy_pulse_ndone", 32'(ndone), 32'd1);
    check("busy_pulse_bcd",   32'(r_bcd), 32'h0777);

    // Asynchronous reset in the middle of the shift phase.
    @(negedge clk);
    numero_input = 16'h1234;
    start_input  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) start_input = 1'b0;
    end
    check("midconv_busy", 32'(busy_output), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy_output), 32'd0);
    check("arst_done", 32'(done_output), 32'd0);
    check("arst_ovf",  32'(overflow_output), 32'd0);
    check("arst_bcd",  32'(bcd_output), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done_output || busy_output) ndone++;
    end
    check("arst_no_resume", 32'(ndone), 32'd0);
    run_conv(16'h00FF, 30, r_bcd, r_ovf, lat, ndone, nbusy);
    check("post_rst_bcd",   32'(r_bcd), 32'h0255);
    check("post_rst_ovf",   32'(r_ovf), 32'd0);
    check("post_rst_ndone", 32'(ndone), 32'd1);

    // 8-bit / 3-digit instance.
    @(negedge clk);
    num8 = 8'd255; start8 = 1'b1; lat = -1; ndone = 0; nbusy = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (i == 1) start8 = 1'b0;
      if (busy8) nbusy++;
      if (done8) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          check("w8_bcd", 32'(bcd8), 32'h255);
          check("w8_ovf", 32'(ovf8), 32'd0);
        end
      end
    end
    check("w8_lat",   32'(lat),   32'(SYNC + 8 + 2));
    check("w8_busy",  32'(nbusy), 32'd10);
    check("w8_ndone", 32'(ndone), 32'd1);

    // 20-bit / 6-digit instance: 1048575 exceeds 999999 and saturates.
    for (int t = 0; t < 3; t++) begin
      logic [19:0] n;
      logic [23:0] eb;
      logic        eo;
      case (t)
        0:       begin n = 20'd1048575; eb = 24'h999999; eo = 1'b1; end
        1:       begin n = 20'd999999;  eb = 24'h999999; eo = 1'b0; end
        default: begin n = 20'd123456;  eb = 24'h123456; eo = 1'b0; end
      endcase
      @(negedge clk);
      num20 = n; start20 = 1'b1; lat = -1; ndone = 0;
      for (int i = 1; i <= 35; i++) begin
        @(posedge clk); #1;
        if (i == 1) start20 = 1'b0;
        if (done20) begin
          ndone++;
          if (lat < 0) begin
            lat = i;
            check($sformatf("w20_%0d_bcd", t), 32'(bcd20), 32'(eb));
            check($sformatf("w20_%0d_ovf", t), 32'(ovf20), 32'(eo));
          end
        end
      end
      check($sformatf("w20_%0d_lat", t),   32'(lat),   32'(SYNC + 20 + 2));
      check($sformatf("w20_%0d_ndone", t), 32'(ndone), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
